small_hb_int: RTL and testbench

- 2x halfband interpolator. Transmit-side counterpart of small_hb_dec; sits in the DUC chain ahead of the CIC interpolator.
- Each strobed input sample produces two strobed output samples:
  - even phase: the delayed input itself;
  - odd phase: a 4-tap interpolated midpoint.
- Fixed coefficients [-1 0 9 16 9 0 -1]/16. Unity gain on both phases. No multipliers; shift-add only.

---
 rtl/small_hb_int.sv | 148 ++++++++++++++
 tb/tb_small_hb_int.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/small_hb_int.sv
// 2x halfband interpolator: each input yields the delayed sample (even phase)
// followed by a shift-add 4-tap midpoint (odd phase), or a straight pass in bypass.
module small_hb_int #(
  parameter int WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bypass,
  input  logic                    stb_in,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    stb_out,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    overrun
);

  localparam int PW = WIDTH + 5;

  logic signed [WIDTH-1:0] x0_q, x1_q, x2_q, x3_q;
  logic signed [WIDTH-1:0] x0_d, x1_d, x2_d, x3_d;
  logic                    v1_q, v2_q, v3_q;
  logic                    v1_d, v2_d, v3_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [WIDTH-1:0] even_q, even_d, odd_q, odd_d;
  logic signed [WIDTH-1:0] data_out_q, data_out_d;
  logic                    stb_out_q, stb_out_d;
  logic                    overrun_q, overrun_d;
  logic                    stb_prev_q, stb_prev_d;
  logic                    bypass_q, bypass_d;

  logic signed [WIDTH:0]   sa, sb;
  logic signed [PW-1:0]    sa_x, sb_x, p, p_rnd;
  logic signed [WIDTH-1:0] odd_sat;
  logic                    rnd_fits;

  // p = 9*sa - sb computed as (sa<<3)+sa-sb; PW bits hold it exactly.
  assign sa    = {x1_q[WIDTH-1], x1_q} + {x2_q[WIDTH-1], x2_q};
  assign sb    = {x0_q[WIDTH-1], x0_q} + {x3_q[WIDTH-1], x3_q};
  assign sa_x  = PW'(sa);
  assign sb_x  = PW'(sb);
  assign p     = (sa_x <<< 3) + sa_x - sb_x;

  assign p_rnd    = (p_q + PW'(8)) >>> 4;
  assign rnd_fits = (p_rnd[PW-1:WIDTH-1] == {(PW-WIDTH+1){p_rnd[PW-1]}});
  assign odd_sat  = rnd_fits ? p_rnd[WIDTH-1:0]
                             : {p_rnd[PW-1], {(WIDTH-1){~p_rnd[PW-1]}}};

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    x0_d       = x0_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    x3_d       = x3_q;
    p_d        = p_q;
    even_d     = even_q;
    odd_d      = odd_q;
    data_out_d = data_out_q;
    v1_d       = 1'b0;
    v2_d       = 1'b0;
    v3_d       = 1'b0;
    stb_out_d  = 1'b0;
    bypass_d   = bypass;
    stb_prev_d = stb_in;
    overrun_d  = overrun_q | (stb_in & stb_prev_q);

    if (bypass != bypass_q) begin
      // Mode change flushes everything except the sticky overrun flag.
      x0_d       = '0;
      x1_d       = '0;
      x2_d       = '0;
      x3_d       = '0;
      p_d        = '0;
      even_d     = '0;
      odd_d      = '0;
      data_out_d = '0;
    end else if (bypass) begin
      if (stb_in) begin
        stb_out_d  = 1'b1;
        data_out_d = data_in;
      end
    end else begin
      if (stb_in) begin
        x3_d = x2_q;
        x2_d = x1_q;
        x1_d = x0_q;
        x0_d = data_in;
        v1_d = 1'b1;
      end
      if (v1_q) begin
        p_d    = p;
        even_d = x2_q;
        v2_d   = 1'b1;
      end
      if (v2_q) begin
        stb_out_d  = 1'b1;
        data_out_d = even_q;
        odd_d      = odd_sat;
        v3_d       = 1'b1;
      end
      if (v3_q) begin
        stb_out_d  = 1'b1;
        data_out_d = odd_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: pipeline data is cleared too, so data_out reads 0 right after reset.
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      p_q        <= '0;
      even_q     <= '0;
      odd_q      <= '0;
      data_out_q <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      stb_out_q  <= 1'b0;
      overrun_q  <= 1'b0;
      stb_prev_q <= 1'b0;
      bypass_q   <= bypass;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      x3_q       <= x3_d;
      p_q        <= p_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
      data_out_q <= data_out_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      stb_out_q  <= stb_out_d;
      overrun_q  <= overrun_d;
      stb_prev_q <= stb_prev_d;
      bypass_q   <= bypass_d;
    end
  end

  assign stb_out  = stb_out_q;
  assign data_out = data_out_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_small_hb_int.sv
// Bench for small_hb_int: per-cycle scoreboard fed by an arithmetic model of the
// halfband rules, directed plan cases with literal expectations, then random traffic.
module tb_small_hb_int;

  localparam int WIDTH = 18;
  localparam int MAXC  = 8192;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    bypass = 1'b0;
  logic                    stb_in = 1'b0;
  logic signed [WIDTH-1:0] data_in = '0;
  logic                    stb_out;
  logic signed [WIDTH-1:0] data_out;
  logic                    overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected behaviour per cycle: strobe, data, overrun, and whether strobe/data are defined.
  logic                    ev [MAXC];
  logic signed [WIDTH-1:0] ed [MAXC];
  logic                    eo [MAXC];
  logic                    en [MAXC];

  longint                  hist[$];
  int                      last_stb = -10;
  logic signed [WIDTH-1:0] got[$];

  small_hb_int #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bypass(bypass), .stb_in(stb_in), .data_in(data_in),
    .stb_out(stb_out), .data_out(data_out), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint h(int k);
    return (k < hist.size()) ? hist[k] : 64'sd0;
  endfunction

  function automatic logic signed [WIDTH-1:0] clip(longint v);
    longint hi, lo;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return WIDTH'(v);
  endfunction

  // Midpoint of in[n-1],in[n-2]: (-x0 + 9x1 + 9x2 - x3)/16, rounded half up.
  function automatic logic signed [WIDTH-1:0] midpoint();
    longint p, n, q;
    p = 9 * (h(1) + h(2)) - h(0) - h(3);
    n = p + 8;
    q = n / 16;
    if ((n % 16 != 0) && (n < 0)) q = q - 1;
    return clip(q);
  endfunction

  function automatic logic signed [31:0] got_at(int i);
    return (i < got.size()) ? 32'(got[i]) : 'x;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [WIDTH-1:0] d, input int gap);
    int t;
    t = cyc;
    if (t == last_stb + 1) begin
      for (int c = t + 1; c < MAXC; c++) eo[c] = 1'b1;
      for (int c = t; c < MAXC; c++) en[c] = 1'b0;
    end
    last_stb = t;
    if (bypass) begin
      ev[t+1] = 1'b1;
      ed[t+1] = d;
    end else begin
      hist.push_front(longint'(d));
      if (hist.size() > 4) void'(hist.pop_back());
      ev[t+3] = 1'b1;
      ed[t+3] = clip(h(2));
      ev[t+4] = 1'b1;
      ed[t+4] = midpoint();
    end
    stb_in  = 1'b1;
    data_in = d;
    tick();
    stb_in  = 1'b0;
    for (int i = 1; i < gap; i++) tick();
  endtask

  task automatic set_bypass(input logic b);
    for (int c = cyc + 1; c < MAXC; c++) ev[c] = 1'b0;
    hist.delete();
    bypass = b;
    tick();
    check("byp_switch_stb", stb_out, 0);
  endtask

  task automatic do_reset();
    for (int c = cyc + 1; c < MAXC; c++) begin
      ev[c] = 1'b0;
      eo[c] = 1'b0;
      en[c] = 1'b1;
    end
    hist.delete();
    last_stb = -10;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_stb", stb_out, 0);
    check("rst_data", data_out, 0);
    check("rst_ovr", overrun, 0);
  endtask

  task automatic impulse_run();
    int exp_seq[10] = '{0, -1024, 0, 9216, 16384, 9216, 0, -1024, 0, 0};
    got.delete();
    send(18'sd16384, 4);
    for (int i = 0; i < 7; i++) send('0, 4);
    repeat (2) tick();
    check("imp_count", got.size(), 16);
    for (int i = 0; i < 10; i++) check("imp_value", got_at(i), exp_seq[i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      check("overrun", overrun, eo[cyc]);
      if (en[cyc]) begin
        check("stb_out", stb_out, ev[cyc]);
        if (ev[cyc]) check("data_out", data_out, ed[cyc]);
      end
      if (stb_out) got.push_back(data_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      ev[c] = 1'b0;
      ed[c] = '0;
      eo[c] = 1'b0;
      en[c] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    check("init_stb", stb_out, 0);
    check("init_data", data_out, 0);
    check("init_ovr", overrun, 0);

    // Impulse response
    do_reset();
    impulse_run();

    // DC at the maximum input rate
    do_reset();
    got.delete();
    for (int i = 0; i < 10; i++) send(18'sd1000, 2);
    repeat (3) tick();
    check("dc_count", got.size(), 20);
    for (int i = 6; i < 20; i++) check("dc_value", got_at(i), 1000);

    // Rounding half up on the odd phase
    do_reset();
    got.delete();
    send(-18'sd8, 3);
    for (int i = 0; i < 3; i++) send('0, 3);
    repeat (2) tick();
    check("round_neg8", got_at(1), 1);
    do_reset();
    got.delete();
    send(18'sd8, 3);
    for (int i = 0; i < 3; i++) send('0, 3);
    repeat (2) tick();
    check("round_pos8", got_at(1), 0);

    // Saturation, both directions
    do_reset();
    got.delete();
    send(-18'sd131072, 3); send(18'sd131071, 3); send(18'sd131071, 3); send(-18'sd131072, 3);
    repeat (2) tick();
    check("sat_hi_even", got_at(6), 131071);
    check("sat_hi_odd", got_at(7), 131071);
    do_reset();
    got.delete();
    send(18'sd131071, 3); send(-18'sd131072, 3); send(-18'sd131072, 3); send(18'sd131071, 3);
    repeat (2) tick();
    check("sat_lo_even", got_at(6), -131072);
    check("sat_lo_odd", got_at(7), -131072);

    // Bypass, mid-pair mode switches, delay line flushed
    do_reset();
    send(18'sd3000, 2);
    send(-18'sd2000, 3);
    set_bypass(1'b1);
    got.delete();
    send(18'sd5, 3);
    send(-18'sd7, 3);
    check("byp_count", got.size(), 2);
    check("byp_first", got_at(0), 5);
    check("byp_second", got_at(1), -7);
    set_bypass(1'b0);
    impulse_run();

    // Overrun, then reset between the two phases of a pair
    do_reset();
    send(18'sd100, 1);
    send(18'sd200, 3);
    check("ovr_set", overrun, 1);
    repeat (5) tick();
    check("ovr_sticky", overrun, 1);
    do_reset();
    send(18'sd16384, 3);
    do_reset();

    // Random traffic with occasional mode switches and resets
    for (int i = 0; i < 300; i++) begin
      int r;
      logic signed [WIDTH-1:0] d;
      r = int'($urandom_range(0, 99));
      if (r < 4) set_bypass(!bypass);
      else if (r < 6) do_reset();
      else begin
        if ($urandom_range(0, 1) == 1) d = WIDTH'($urandom);
        else d = WIDTH'(int'($urandom_range(0, 8191)) - 4096);
        send(d, int'($urandom_range(2, 5)));
      end
    end
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
